// File: rtl/ifetch_queue_pkg.sv
// Shared CPU front-end parameters for the instruction fetch queue.
package ifetch_queue_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned IQ_DEPTH        = 4;
  localparam logic [31:0] I_MEM_BASE_ADDR = 32'h0000_0000;

endpackage

// File: rtl/ifetch_queue_sync_fifo.sv
// Flushable synchronous FIFO; the read port holds the last popped word when empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] last;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Storage needs no reset: it is only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        last   <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = (count != '0) ? mem[rd_ptr] : last;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front-end: sequential word fetch, credit-limited issue,
// one-cycle memory response capture and redirect flush.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int unsigned     BITS       = XLEN,
  parameter int unsigned     DEPTH      = IQ_DEPTH,
  parameter logic [BITS-1:0] RESET_ADDR = BITS'(I_MEM_BASE_ADDR)
) (
  input  logic            clk,
  input  logic            rst_,
  output logic            fetch_req,
  output logic [BITS-1:0] fetch_addr,
  input  logic [BITS-1:0] mem_rdata,
  output logic [BITS-1:0] instr,
  output logic [BITS-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            redirect,
  input  logic [BITS-1:0] redirect_addr,
  input  logic            halt
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned OW = CW + 1;

  logic              started;
  logic              rsp_valid;
  logic [BITS-1:0]   next_pc;
  logic [BITS-1:0]   rsp_pc;
  logic [CW-1:0]     count;
  logic [OW-1:0]     occupancy;
  logic              push;
  logic              pop;
  logic [2*BITS-1:0] head;

  // Credit counts the in-flight response so a capture can never overflow the FIFO.
  always_comb begin
    occupancy = OW'(count) + OW'(rsp_valid);
    fetch_req = started & ~halt & ~redirect & (occupancy < OW'(DEPTH));
    push      = rsp_valid & ~redirect;
    pop       = instr_valid & instr_ready & ~redirect;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      started   <= 1'b0;
      next_pc   <= RESET_ADDR;
      rsp_valid <= 1'b0;
      rsp_pc    <= '0;
    end else begin
      started <= 1'b1;
      if (redirect) begin
        next_pc   <= redirect_addr;
        rsp_valid <= 1'b0;
      end else begin
        rsp_valid <= fetch_req;
        if (fetch_req) begin
          next_pc <= next_pc + BITS'(1);
          rsp_pc  <= next_pc;
        end
      end
    end
  end

  sync_fifo #(
    .WIDTH (2*BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_  (rst_),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata ({mem_rdata, rsp_pc}),
    .rdata (head),
    .count (count)
  );

  assign fetch_addr        = next_pc;
  assign instr_valid       = (count != '0);
  assign {instr, instr_pc} = head;

endmodule
